// File: rtl/semaphore_bank_pkg.sv
// Shared encodings and sizing helper for the semaphore bank controller.
// Op codes, status values and a clog2 that never returns less than 1.
package semaphore_bank_pkg;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_ACQUIRE = 2'b01,
      OP_RELEASE = 2'b10,
      OP_WRITE   = 2'b11
   } op_e;

   localparam logic STATUS_OK   = 1'b1;
   localparam logic STATUS_FAIL = 1'b0;

   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/semaphore_bank_controller_if.sv
// Core-side request/response bundle of the semaphore bank, flattened per core.
// The cores drive through master; the bank uses slave.
interface semaphore_bank_if
   import semaphore_bank_pkg::*;
#(
   parameter int NumberOfSemaphores = 4,
   parameter int NumberOfCores      = 2,
   parameter int DataWidth          = 4
);
   localparam int SelWidth = clog2_min1(NumberOfSemaphores);

   logic [NumberOfCores-1:0]           Req;
   logic [2*NumberOfCores-1:0]         Op;
   logic [SelWidth*NumberOfCores-1:0]  Sel;
   logic [DataWidth*NumberOfCores-1:0] WData;
   logic [NumberOfCores-1:0]           Clear;
   logic [NumberOfCores-1:0]           Ack;
   logic [NumberOfCores-1:0]           Status;
   logic [DataWidth*NumberOfCores-1:0] RData;
   logic [NumberOfSemaphores-1:0]      Locked;

   modport master (
      output Req, Op, Sel, WData, Clear,
      input  Ack, Status, RData, Locked
   );

   modport slave (
      input  Req, Op, Sel, WData, Clear,
      output Ack, Status, RData, Locked
   );

endinterface

// File: rtl/semaphore_bank_controller_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant among unmasked requesters, searching
// from the last granted index + 1; the pointer resets so index 0 wins first.
module round_robin_arbiter
   import semaphore_bank_pkg::*;
#(
   parameter int N = 2,
   localparam int IdW = clog2_min1(N)
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic [N-1:0]   i_req,
   input  logic [N-1:0]   i_mask,
   output logic [N-1:0]   o_grant,
   output logic [IdW-1:0] o_grant_idx,
   output logic           o_grant_vld
);

   logic [IdW-1:0] r_ptr;
   logic [N-1:0]   w_elig;

   assign w_elig = i_req & ~i_mask;

   // First pass covers indices above the pointer, second pass wraps to the rest.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_grant_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!o_grant_vld && w_elig[i] && (i > int'(r_ptr))) begin
            o_grant_vld = 1'b1;
            o_grant[i]  = 1'b1;
            o_grant_idx = IdW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!o_grant_vld && w_elig[i]) begin
            o_grant_vld = 1'b1;
            o_grant[i]  = 1'b1;
            o_grant_idx = IdW'(i);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= IdW'(N - 1);
      end else if (o_grant_vld) begin
         r_ptr <= o_grant_idx;
      end
   end

endmodule

// File: rtl/semaphore_bank_controller.sv
// Registered semaphore bank: lock/owner/data entries shared by all cores,
// one arbitrated operation per cycle, results returned one cycle after grant.
module semaphore_bank_controller
   import semaphore_bank_pkg::*;
#(
   parameter int NumberOfSemaphores = 4,
   parameter int NumberOfCores      = 2,
   parameter int DataWidth          = 4
)(
   input logic             SEMAPHOREBANK_Clk,
   input logic             SEMAPHOREBANK_nReset,
   semaphore_bank_if.slave SEMAPHOREBANK
);

   localparam int SelWidth = clog2_min1(NumberOfSemaphores);
   localparam int IdWidth  = clog2_min1(NumberOfCores);

   logic [NumberOfSemaphores-1:0]      r_locked;
   logic [IdWidth-1:0]                 r_owner [NumberOfSemaphores];
   logic [DataWidth-1:0]               r_data  [NumberOfSemaphores];
   logic [NumberOfCores-1:0]           r_ack;
   logic [NumberOfCores-1:0]           r_status;
   logic [DataWidth*NumberOfCores-1:0] r_rdata;

   logic [NumberOfCores-1:0] w_grant;
   logic [IdWidth-1:0]       w_gidx;
   logic                     w_gvld;

   // A core is ineligible during its Ack cycle and while it is being cleared.
   round_robin_arbiter #(.N(NumberOfCores)) u_arb (
      .i_clk       (SEMAPHOREBANK_Clk),
      .i_rst_n     (SEMAPHOREBANK_nReset),
      .i_req       (SEMAPHOREBANK.Req),
      .i_mask      (r_ack | SEMAPHOREBANK.Clear),
      .o_grant     (w_grant),
      .o_grant_idx (w_gidx),
      .o_grant_vld (w_gvld)
   );

   logic [1:0]           w_op;
   logic [SelWidth-1:0]  w_sel;
   logic [DataWidth-1:0] w_wdata;
   logic [DataWidth-1:0] w_cur;
   logic [DataWidth-1:0] w_rd;
   logic                 w_in_range;
   logic                 w_is_free;
   logic                 w_is_owner;
   logic                 w_ok;
   logic                 w_set_lock;
   logic                 w_clr_lock;
   logic                 w_wr;

   always_comb begin
      w_op    = '0;
      w_sel   = '0;
      w_wdata = '0;
      for (int c = 0; c < NumberOfCores; c++) begin
         if (w_grant[c]) begin
            w_op    = SEMAPHOREBANK.Op[2*c +: 2];
            w_sel   = SEMAPHOREBANK.Sel[c*SelWidth +: SelWidth];
            w_wdata = SEMAPHOREBANK.WData[c*DataWidth +: DataWidth];
         end
      end
   end

   // Decisions use the pre-edge bank state; out-of-range selects touch nothing.
   always_comb begin
      w_in_range = (32'(w_sel) < 32'(NumberOfSemaphores));
      w_cur      = w_in_range ? r_data[w_sel] : '0;
      w_is_free  = w_in_range && !r_locked[w_sel];
      w_is_owner = w_in_range && r_locked[w_sel] && (r_owner[w_sel] == w_gidx);
      w_ok       = 1'b0;
      w_set_lock = 1'b0;
      w_clr_lock = 1'b0;
      w_wr       = 1'b0;
      case (w_op)
         OP_READ: begin
            w_ok = w_in_range;
         end
         OP_ACQUIRE: begin
            w_ok       = w_is_free || w_is_owner;
            w_set_lock = w_is_free;
         end
         OP_RELEASE: begin
            w_ok       = w_is_owner;
            w_clr_lock = w_is_owner;
         end
         default: begin
            w_ok = w_is_owner;
            w_wr = w_is_owner;
         end
      endcase
      w_rd = w_wr ? w_wdata : w_cur;
   end

   always_ff @(posedge SEMAPHOREBANK_Clk or negedge SEMAPHOREBANK_nReset) begin
      if (!SEMAPHOREBANK_nReset) begin
         r_locked <= '0;
         r_ack    <= '0;
         r_status <= '0;
         r_rdata  <= '0;
         for (int s = 0; s < NumberOfSemaphores; s++) begin
            r_owner[s] <= '0;
            r_data[s]  <= '0;
         end
      end else begin
         r_ack <= w_grant;
         // A clearing core never holds the grant, so its unlocks cannot collide with the op.
         for (int s = 0; s < NumberOfSemaphores; s++) begin
            if (r_locked[s] && SEMAPHOREBANK.Clear[r_owner[s]]) begin
               r_locked[s] <= 1'b0;
            end
         end
         if (w_gvld) begin
            for (int c = 0; c < NumberOfCores; c++) begin
               if (w_grant[c]) begin
                  r_status[c]                         <= w_ok ? STATUS_OK : STATUS_FAIL;
                  r_rdata[c*DataWidth +: DataWidth]   <= w_rd;
               end
            end
            if (w_set_lock) begin
               r_locked[w_sel] <= 1'b1;
               r_owner[w_sel]  <= w_gidx;
            end
            if (w_clr_lock) begin
               r_locked[w_sel] <= 1'b0;
            end
            if (w_wr) begin
               r_data[w_sel] <= w_wdata;
            end
         end
      end
   end

   assign SEMAPHOREBANK.Ack    = r_ack;
   assign SEMAPHOREBANK.Status = r_status;
   assign SEMAPHOREBANK.RData  = r_rdata;
   assign SEMAPHOREBANK.Locked = r_locked;

endmodule

// File: tb/tb_semaphore_bank_controller.sv
// Bench for semaphore_bank_controller: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the bank.
module tb_semaphore_bank_controller;
   import semaphore_bank_pkg::*;

   localparam int NS  = 4;
   localparam int NC  = 2;
   localparam int DW  = 4;
   localparam int SW  = clog2_min1(NS);
   localparam int RD  = 0;
   localparam int ACQ = 1;
   localparam int REL = 2;
   localparam int WR  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   semaphore_bank_if #(.NumberOfSemaphores(NS), .NumberOfCores(NC), .DataWidth(DW)) bus();
   semaphore_bank_if #(.NumberOfSemaphores(5), .NumberOfCores(2), .DataWidth(4)) bus5();

   semaphore_bank_controller #(.NumberOfSemaphores(NS), .NumberOfCores(NC), .DataWidth(DW)) dut (
      .SEMAPHOREBANK_Clk    (clk),
      .SEMAPHOREBANK_nReset (rst_n),
      .SEMAPHOREBANK        (bus)
   );

   semaphore_bank_controller #(.NumberOfSemaphores(5), .NumberOfCores(2), .DataWidth(4)) dut5 (
      .SEMAPHOREBANK_Clk    (clk),
      .SEMAPHOREBANK_nReset (rst_n),
      .SEMAPHOREBANK        (bus5)
   );

   // Model of the bank and of what the outputs must show after each edge.
   bit m_locked [NS];
   int m_owner  [NS];
   int m_data   [NS];
   int m_ptr;
   bit m_ack    [NC];
   int m_status [NC];
   int m_rdata  [NC];

   bit q_req [NC];
   bit q_clr [NC];
   int q_op  [NC];
   int q_sel [NC];
   int q_wd  [NC];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         m_locked[s] = 1'b0;
         m_owner[s]  = 0;
         m_data[s]   = 0;
      end
      for (int c = 0; c < NC; c++) begin
         m_ack[c]    = 1'b0;
         m_status[c] = 0;
         m_rdata[c]  = 0;
         q_req[c]    = 1'b0;
         q_clr[c]    = 1'b0;
      end
      m_ptr = NC - 1;
   endtask

   task automatic drive();
      for (int c = 0; c < NC; c++) begin
         bus.Req[c]             = q_req[c];
         bus.Clear[c]           = q_clr[c];
         bus.Op[2*c +: 2]       = 2'(q_op[c]);
         bus.Sel[c*SW +: SW]    = SW'(q_sel[c]);
         bus.WData[c*DW +: DW]  = DW'(q_wd[c]);
      end
   endtask

   // One clock edge of the bank, straight from the operation rules.
   task automatic model_step();
      int  g, s, rd;
      bit  ok, mine, free;
      g  = -1;
      s  = 0;
      rd = 0;
      ok = 1'b0;
      for (int k = 1; k <= NC; k++) begin
         int c;
         c = (m_ptr + k) % NC;
         if (g < 0 && q_req[c] && !m_ack[c] && !q_clr[c]) g = c;
      end
      for (int c = 0; c < NC; c++) m_ack[c] = 1'b0;
      if (g >= 0) begin
         s = q_sel[g];
         m_ptr = g;
         m_ack[g] = 1'b1;
         if (s < NS) begin
            mine = m_locked[s] && (m_owner[s] == g);
            free = !m_locked[s];
            rd   = m_data[s];
            case (q_op[g])
               RD:      ok = 1'b1;
               ACQ:     ok = free || mine;
               default: ok = mine;
            endcase
         end
      end
      for (int e = 0; e < NS; e++) begin
         if (m_locked[e] && q_clr[m_owner[e]]) m_locked[e] = 1'b0;
      end
      if (g >= 0) begin
         if (ok && s < NS) begin
            case (q_op[g])
               ACQ: begin m_locked[s] = 1'b1; m_owner[s] = g; end
               REL: m_locked[s] = 1'b0;
               WR:  begin m_data[s] = q_wd[g]; rd = q_wd[g]; end
               default: ;
            endcase
         end
         m_status[g] = ok ? 1 : 0;
         m_rdata[g]  = rd;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] lk;
      lk = '0;
      for (int s = 0; s < NS; s++) if (m_locked[s]) lk[s] = 1'b1;
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("ack%0d", c), 32'(bus.Ack[c]), 32'(m_ack[c]));
         if (m_ack[c]) begin
            chk($sformatf("status%0d", c), 32'(bus.Status[c]), 32'(m_status[c]));
            chk($sformatf("rdata%0d", c), 32'(bus.RData[c*DW +: DW]), 32'(m_rdata[c]));
         end
      end
      chk("locked", 32'(bus.Locked), lk);
   endtask

   task automatic step();
      drive();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic issue(input int c, input int op, input int sel, input int wd,
                        input int exp_st, input int exp_rd, input string tag);
      int n;
      n = 0;
      q_req[c] = 1'b1;
      q_op[c]  = op;
      q_sel[c] = sel;
      q_wd[c]  = wd;
      do begin
         step();
         n++;
      end while (!m_ack[c] && n < 8);
      chk({tag, "_ack"}, 32'(bus.Ack[c]), 32'd1);
      chk({tag, "_status"}, 32'(bus.Status[c]), 32'(exp_st));
      chk({tag, "_rdata"}, 32'(bus.RData[c*DW +: DW]), 32'(exp_rd));
      q_req[c] = 1'b0;
   endtask

   task automatic op5(input int op, input int sel, input int wd,
                      input int exp_st, input int exp_rd, input int exp_lk, input string tag);
      bus5.Req   = 2'b01;
      bus5.Clear = 2'b00;
      bus5.Op    = {2'b00, 2'(op)};
      bus5.Sel   = {3'b000, 3'(sel)};
      bus5.WData = {4'h0, 4'(wd)};
      step();
      chk({tag, "_ack"}, 32'(bus5.Ack), 32'd1);
      chk({tag, "_status"}, 32'(bus5.Status[0]), 32'(exp_st));
      chk({tag, "_rdata"}, 32'(bus5.RData[3:0]), 32'(exp_rd));
      chk({tag, "_locked"}, 32'(bus5.Locked), 32'(exp_lk));
      bus5.Req = 2'b00;
      step();
   endtask

   initial begin
      for (int c = 0; c < NC; c++) begin
         q_op[c] = 0; q_sel[c] = 0; q_wd[c] = 0;
      end
      model_reset();
      drive();
      bus5.Req = '0; bus5.Clear = '0; bus5.Op = '0; bus5.Sel = '0; bus5.WData = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      chk("reset_ack", 32'(bus.Ack), 32'd0);
      chk("reset_status", 32'(bus.Status), 32'd0);
      chk("reset_rdata", 32'(bus.RData), 32'd0);
      chk("reset_locked", 32'(bus.Locked), 32'd0);

      issue(0, ACQ, 2, 0, 1, 0, "acq0_s2");
      chk("lk_after_acq0", 32'(bus.Locked), 32'h4);
      issue(1, ACQ, 2, 0, 0, 0, "acq1_s2");
      chk("lk_after_acq1", 32'(bus.Locked), 32'h4);
      issue(0, WR, 2, 'hA, 1, 'hA, "wr0_s2");
      issue(1, WR, 2, 5, 0, 'hA, "wr1_s2");
      issue(1, RD, 2, 0, 1, 'hA, "rd1_s2");

      issue(1, ACQ, 0, 0, 1, 0, "acq1_s0");
      issue(1, ACQ, 3, 0, 1, 0, "acq1_s3");
      issue(1, WR, 3, 7, 1, 7, "wr1_s3");
      chk("lk_core1_owns", 32'(bus.Locked), 32'hD);
      q_clr[1] = 1'b1;
      issue(0, ACQ, 3, 0, 0, 7, "acq0_vs_clear");
      q_clr[1] = 1'b0;
      chk("lk_after_clear", 32'(bus.Locked), 32'h4);
      issue(0, ACQ, 3, 0, 1, 7, "acq0_retry");
      chk("lk_after_retry", 32'(bus.Locked), 32'hC);
      issue(0, REL, 1, 0, 0, 0, "rel0_notowned");
      chk("lk_after_badrel", 32'(bus.Locked), 32'hC);

      op5(ACQ, 4, 0, 1, 0, 'h10, "n5_acq4");
      op5(WR, 4, 9, 1, 9, 'h10, "n5_wr4");
      op5(WR, 5, 3, 0, 0, 'h10, "n5_wr5");
      op5(RD, 7, 0, 0, 0, 'h10, "n5_rd7");
      op5(REL, 5, 0, 0, 0, 'h10, "n5_rel5");
      op5(RD, 4, 0, 1, 9, 'h10, "n5_rd4");

      // Reset lands between edges with core0's request still waiting for its grant.
      q_req[0] = 1'b1; q_op[0] = ACQ; q_sel[0] = 1;
      drive();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ack", 32'(bus.Ack), 32'd0);
      chk("midrst_status", 32'(bus.Status), 32'd0);
      chk("midrst_rdata", 32'(bus.RData), 32'd0);
      chk("midrst_locked", 32'(bus.Locked), 32'd0);
      model_reset();
      drive();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < NC; c++) begin
         q_req[c] = 1'b1; q_op[c] = RD; q_sel[c] = c;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("alt%0d", i), 32'(bus.Ack), (i % 2 == 0) ? 32'd1 : 32'd2);
      end

      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int c = 0; c < NC; c++) begin
            if (m_ack[c] || !q_req[c]) begin
               q_req[c] = ($urandom_range(0, 3) != 0);
               q_op[c]  = int'($urandom_range(0, 3));
               q_sel[c] = int'($urandom_range(0, NS - 1));
               q_wd[c]  = int'($urandom_range(0, 15));
            end
            q_clr[c] = ($urandom_range(0, 19) == 0);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/semaphore_bank_controller.md
# semaphore_bank_controller

Registered semaphore bank shared by all PLC cores: holds NumberOfSemaphores lock/owner/data entries and serves acquire, release, write and read operations from NumberOfCores request ports. One round-robin arbiter grants at most one operation per cycle. This replaces the combinational, write-enable-steered tristate data fan-out with owned, arbitrated, clocked storage. It sits between the cores' bus decoders and the shared semaphore resources.

## Interface
- NumberOfSemaphores, 4, number of semaphore entries (≥1)
- NumberOfCores, 2, number of requesting cores (≥2)
- DataWidth, 4, payload bits per semaphore
- Derived: SelWidth = max(1, clog2(NumberOfSemaphores)), IdWidth = max(1, clog2(NumberOfCores))

Ports:
- SEMAPHOREBANK_Clk  in  1  single clock, all state on rising edge
- SEMAPHOREBANK_nReset  in  1  asynchronous, active-low reset
- SEMAPHOREBANK_Req  in  NumberOfCores  per-core request valid
- SEMAPHOREBANK_Op  in  2*NumberOfCores  per-core op: 00 READ, 01 ACQUIRE, 10 RELEASE, 11 WRITE
- SEMAPHOREBANK_Sel  in  SelWidth*NumberOfCores  per-core semaphore index
- SEMAPHOREBANK_WData  in  DataWidth*NumberOfCores  per-core write payload
- SEMAPHOREBANK_Clear  in  NumberOfCores  per-core force-release (core reset/watchdog)
- SEMAPHOREBANK_Ack  out  NumberOfCores  one-cycle completion pulse per core
- SEMAPHOREBANK_Status  out  NumberOfCores  1 = OK, 0 = FAIL; valid with Ack
- SEMAPHOREBANK_RData  out  DataWidth*NumberOfCores  entry data after op; valid with Ack
- SEMAPHOREBANK_Locked  out  NumberOfSemaphores  per-entry lock flag

## Operation
- Per entry: Locked bit, Owner (IdWidth), Data (DataWidth).
- Eligible core: Req=1, Ack=0 this cycle, Clear=0. The arbiter picks one eligible core, starting search at last granted + 1, wrapping.
- Granted op against pre-edge state, core c, entry s:
  - READ: always OK; RData = Data[s].
  - ACQUIRE: free → Locked=1, Owner=c, OK. Owned by c → OK, no change. Owned by another core → FAIL.
  - RELEASE: owned by c → Locked=0, OK. Otherwise FAIL, no change.
  - WRITE: owned by c → Data[s]=WData, OK, RData = new data. Otherwise FAIL, no change.
- Sel ≥ NumberOfSemaphores: FAIL, no state change, RData=0.
- FAIL on any op: RData = current Data[s] (0 if out of range).
- Clear[c]=1: every entry with Locked=1 and Owner=c is unlocked at the edge. Data is preserved. Core c is masked from arbitration while Clear is high.
- Simultaneous Clear[c] and another core's ACQUIRE of an entry owned by c in the same cycle: the ACQUIRE sees pre-clear state → FAIL. It can succeed on retry the next cycle.
- Request fields must stay stable from Req rise until Ack.

## Timing
- Grant is combinational in cycle N. Bank update, Ack, Status and RData are registered and visible in cycle N+1. Latency is 1 cycle from grant.
- Ack is a single-cycle pulse. In the Ack cycle the core is ineligible, so it either drops Req or presents the next op, which is eligible from N+2. Max rate is one op per core every 2 cycles and one op per cycle for the bank.
- Locked reflects the registered state (updates at the same edge as Ack).
- Reset (async, any time, including mid-operation): all Locked=0, Owner=0, Data=0, Ack=0, Status=0, RData=0. The RR pointer resets to NumberOfCores-1, so core 0 wins first. A request pending at reset is dropped with no Ack, and the core must re-issue it.
- Non-granted requests wait, with no timeout. Round-robin bounds the wait to NumberOfCores-1 grants.

## Structure
- Package semaphore_bank_pkg: op encodings (OP_READ, OP_ACQUIRE, OP_RELEASE, OP_WRITE), status constants, clog2 helper for SelWidth/IdWidth.
- Sub-module round_robin_arbiter (parameter N; req/mask in, one-hot grant out, pointer register inside, async active-low reset).
- The top level holds the entry arrays, op decode, clear logic and output registers.

## Test plan
- Reset then core0 ACQUIRE sel=2 → next cycle Ack[0]=1, Status=1, Locked=4'b0100. Then core1 ACQUIRE sel=2 → Status=0, Locked unchanged.
- Core0 WRITE sel=2 data=4'hA while owning → OK, RData=A. Core1 WRITE sel=2 data=5 → FAIL, RData=A. Core1 READ sel=2 → OK, RData=A.
- Both cores request every cycle from reset → grants alternate 0,1,0,1. Each core gets Ack every 2 cycles and no Ack is ever lost.
- Core1 owns sel 0 and 3; pulse Clear[1] together with core0 ACQUIRE sel=3 → FAIL. Locked=0 next cycle, Data kept. Core0 retry → OK.
- Core0 RELEASE sel=1 not owned → FAIL. Sel=5 with NumberOfSemaphores=5 (SelWidth=3) → FAIL, RData=0, no change.
- Assert nReset mid-request (Req high, before Ack) → outputs and Locked immediately 0, no Ack. After release, core0 is granted first.
